jls_frame_ctrl: RTL and testbench

JLS_FRAME_CTRL -- requirements
Module: jls_frame_ctrl

---
 rtl/jls_pkg.sv | 16 +
 rtl/jls_pix_counter.sv | 42 ++++
 rtl/jls_frame_ctrl.sv | 133 +++++++++++++
 tb/tb_jls_frame_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/jls_pkg.sv
// Shared constants and the FSM state type for the JPEG-LS frame controller.
package jls_pkg;

  localparam int MAXLEN_LEVEL_DEF = 12;
  localparam int MIN_WIDTH        = 4;
  localparam int PRE_CYCLES_DEF   = 368;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_DATA = 3'd2,
    ST_POST = 3'd3,
    ST_FIN  = 3'd4
  } jls_state_e;

endpackage

// File: rtl/jls_pix_counter.sv
// Column/row pixel counters; flags the accept of the last pixel of a frame.
module jls_pix_counter #(
  parameter int MAXLEN_LEVEL = 12
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    clear,
  input  logic                    accept,
  input  logic [MAXLEN_LEVEL-1:0] width,
  input  logic [15:0]             height,
  output logic                    last_pix
);

  localparam logic [MAXLEN_LEVEL-1:0] ONE_W = MAXLEN_LEVEL'(1);

  logic [MAXLEN_LEVEL-1:0] col;
  logic [15:0]             row;
  logic                    col_end;
  logic                    row_end;

  assign col_end  = (col == width - ONE_W);
  assign row_end  = (row == height - 16'd1);
  assign last_pix = accept && col_end && row_end;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col <= '0;
      row <= '0;
    end else if (clear) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col_end) begin
        col <= '0;
        row <= row_end ? 16'd0 : row + 16'd1;
      end else begin
        col <= col + ONE_W;
      end
    end
  end

endmodule

// File: rtl/jls_frame_ctrl.sv
// Frame sequencer feeding a JPEG-LS encoder: preamble, pixel pass-through, drain.
// Optional POST timeout is enabled by defining JLS_CTRL_TIMEOUT_EN.
module jls_frame_ctrl
  import jls_pkg::*;
#(
  parameter int MAXLEN_LEVEL   = MAXLEN_LEVEL_DEF,
  parameter int PRE_CYCLES     = PRE_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start,
  input  logic [MAXLEN_LEVEL-1:0] width,
  input  logic [15:0]             height,
  input  logic                    s_valid,
  input  logic [7:0]              s_data,
  output logic                    s_ready,
  output logic                    enc_inew,
  output logic [MAXLEN_LEVEL-1:0] enc_iwidth,
  output logic [15:0]             enc_iheight,
  output logic                    enc_ivalid,
  output logic [7:0]              enc_idata,
  input  logic                    enc_ovalid,
  input  logic                    enc_olast,
  input  logic                    enc_oerror,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [15:0]             frame_cnt,
  output jls_state_e              state_dbg
);

  // Source handshake: a pixel transfers on a rising edge where s_valid && s_ready.
  // s_ready is a pure function of state, so it never depends on s_valid.

  localparam logic [MAXLEN_LEVEL-1:0] MIN_W    = MAXLEN_LEVEL'(MIN_WIDTH);
  localparam logic [15:0]             PRE_LAST = 16'(PRE_CYCLES - 1);

  jls_state_e state, state_nxt;
  logic [15:0] pre_cnt;
  logic        params_ok;
  logic        accept;
  logic        last_pix;
  logic        err_set;

`ifdef JLS_CTRL_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] to_cnt;
`endif

  assign params_ok = (width >= MIN_W) && (height != 16'd0);
  assign accept    = s_valid && (state == ST_DATA);
  assign s_ready   = (state == ST_DATA);
  assign enc_inew  = (state == ST_PRE) || (state == ST_POST);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_FIN);
  assign state_dbg = state;

  jls_pix_counter #(.MAXLEN_LEVEL(MAXLEN_LEVEL)) u_pix_counter (
    .clk      (clk),
    .rstn     (rstn),
    .clear    (state != ST_DATA),
    .accept   (accept),
    .width    (enc_iwidth),
    .height   (enc_iheight),
    .last_pix (last_pix)
  );

  always_comb begin
    state_nxt = state;
    err_set   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (params_ok) state_nxt = ST_PRE;
          else           err_set   = 1'b1;
        end
      end
      ST_PRE:  if (pre_cnt == PRE_LAST) state_nxt = ST_DATA;
      ST_DATA: if (last_pix) state_nxt = ST_POST;
      ST_POST: begin
        if (enc_ovalid && enc_olast) begin
          state_nxt = ST_FIN;
          err_set   = enc_oerror;
        end
`ifdef JLS_CTRL_TIMEOUT_EN
        else if (to_cnt == TO_LAST) begin
          state_nxt = ST_FIN;
          err_set   = 1'b1;
        end
`endif
      end
      ST_FIN:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // err is registered so a frame error lands in the FIN cycle alongside done.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pre_cnt     <= '0;
      enc_iwidth  <= '0;
      enc_iheight <= '0;
      enc_ivalid  <= 1'b0;
      enc_idata   <= '0;
      err         <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      pre_cnt    <= (state == ST_PRE) ? pre_cnt + 16'd1 : 16'd0;
      enc_ivalid <= accept;
      enc_idata  <= accept ? s_data : 8'd0;
      err        <= err_set;
      if (state == ST_IDLE && start && params_ok) begin
        enc_iwidth  <= width;
        enc_iheight <= height;
      end
      if (state == ST_FIN) frame_cnt <= frame_cnt + 16'd1;
    end
  end

`ifdef JLS_CTRL_TIMEOUT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) to_cnt <= '0;
    else       to_cnt <= (state == ST_POST) ? to_cnt + 16'd1 : 16'd0;
  end
`endif

endmodule

// File: tb/tb_jls_frame_ctrl.sv
// Directed bench for jls_frame_ctrl: pixel scoreboard plus control-path checks.
module tb_jls_frame_ctrl;
  import jls_pkg::*;

  localparam int ML = 12;
`ifdef JLS_CTRL_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 65535;
`endif

  logic          clk, rstn, start;
  logic [ML-1:0] width;
  logic [15:0]   height;
  logic          s_valid, s_ready;
  logic [7:0]    s_data;
  logic          enc_inew, enc_ivalid;
  logic [ML-1:0] enc_iwidth;
  logic [15:0]   enc_iheight;
  logic [7:0]    enc_idata;
  logic          enc_ovalid, enc_olast, enc_oerror;
  logic          busy, done, err;
  logic [15:0]   frame_cnt;
  jls_state_e    state_dbg;

  jls_frame_ctrl #(.MAXLEN_LEVEL(ML), .PRE_CYCLES(368), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rstn(rstn), .start(start), .width(width), .height(height),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .enc_inew(enc_inew), .enc_iwidth(enc_iwidth), .enc_iheight(enc_iheight),
    .enc_ivalid(enc_ivalid), .enc_idata(enc_idata),
    .enc_ovalid(enc_ovalid), .enc_olast(enc_olast), .enc_oerror(enc_oerror),
    .busy(busy), .done(done), .err(err), .frame_cnt(frame_cnt), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  int         checks = 0;
  int         errors = 0;
  int         ivalid_cnt = 0;
  logic       prev_acc = 1'b0;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rstn) begin
      prev_acc = 1'b0;
    end else begin
      if (enc_ivalid) begin
        ivalid_cnt++;
        chk("ivalid_latency", {31'd0, prev_acc}, 32'd1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pixel actual=%0h expected=none", enc_idata);
        end else begin
          chk("pixel_data", {24'd0, enc_idata}, {24'd0, exp_q.pop_front()});
        end
      end else if (enc_idata !== 8'd0) begin
        chk("idata_idle", {24'd0, enc_idata}, 32'd0);
      end
      prev_acc = s_valid && s_ready;
    end
  end

  // driver tasks
  task automatic do_start(input logic [ML-1:0] w, input logic [15:0] h);
    @(posedge clk); #1;
    start = 1'b1; width = w; height = h;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_pre(output int n);
    int t;
    n = 0;
    t = 0;
    while (!s_ready && t < 2000) begin
      if (enc_inew && busy && !enc_ivalid) n++;
      @(posedge clk); #1;
      t++;
    end
    chk("data_reached", {31'd0, s_ready}, 32'd1);
  endtask

  task automatic send_pix(input logic [7:0] d, input int gap);
    int t;
    s_valid = 1'b1;
    s_data  = d;
    t = 0;
    while (!s_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    exp_q.push_back(d);
    @(posedge clk); #1;
    if (gap > 0) begin
      s_valid = 1'b0;
      s_data  = 8'd0;
      repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic finish_frame(input logic oerr, input logic [15:0] exp_frames);
    s_valid = 1'b0;
    s_data  = 8'd0;
    chk("post_s_ready", {31'd0, s_ready}, 32'd0);
    chk("post_inew", {31'd0, enc_inew}, 32'd1);
    repeat (3) begin @(posedge clk); #1; end
    chk("post_wait_busy", {31'd0, busy}, 32'd1);
    chk("post_wait_done", {31'd0, done}, 32'd0);
    enc_ovalid = 1'b1; enc_olast = 1'b1; enc_oerror = oerr;
    @(posedge clk); #1;
    enc_ovalid = 1'b0; enc_olast = 1'b0; enc_oerror = 1'b0;
    chk("fin_done", {31'd0, done}, 32'd1);
    chk("fin_err", {31'd0, err}, {31'd0, oerr});
    chk("fin_busy", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    chk("idle_done", {31'd0, done}, 32'd0);
    chk("idle_err", {31'd0, err}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("frame_cnt", {16'd0, frame_cnt}, {16'd0, exp_frames});
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_s_ready"}, {31'd0, s_ready}, 32'd0);
    chk({tag, "_inew"}, {31'd0, enc_inew}, 32'd0);
    chk({tag, "_ivalid"}, {31'd0, enc_ivalid}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
    chk({tag, "_idata"}, {24'd0, enc_idata}, 32'd0);
    chk({tag, "_iwidth"}, {20'd0, enc_iwidth}, 32'd0);
    chk({tag, "_iheight"}, {16'd0, enc_iheight}, 32'd0);
    chk({tag, "_frame_cnt"}, {16'd0, frame_cnt}, 32'd0);
  endtask

  int n_pre;
  int iv_base;

  initial begin
    rstn = 1'b0; start = 1'b0; width = '0; height = '0;
    s_valid = 1'b0; s_data = '0;
    enc_ovalid = 1'b0; enc_olast = 1'b0; enc_oerror = 1'b0;
    #1;
    chk_all_zero("reset");
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk); #1;
    chk_all_zero("after_reset");

    // frame 1: 4x2, back-to-back pixels 0x10..0x17
    do_start(12'd4, 16'd2);
    chk("f1_iwidth", {20'd0, enc_iwidth}, 32'd4);
    chk("f1_iheight", {16'd0, enc_iheight}, 32'd2);
    wait_pre(n_pre);
    chk("f1_pre_cycles", n_pre, 32'd368);
    for (int i = 0; i < 8; i++) send_pix(8'(8'h10 + i), 0);
    finish_frame(1'b0, 16'd1);

    // invalid starts: width too small, then zero height
    do_start(12'd3, 16'd2);
    chk("bad_w_err", {31'd0, err}, 32'd1);
    chk("bad_w_busy", {31'd0, busy}, 32'd0);
    chk("bad_w_iwidth", {20'd0, enc_iwidth}, 32'd4);
    @(posedge clk); #1;
    chk("bad_w_err_pulse", {31'd0, err}, 32'd0);
    do_start(12'd8, 16'd0);
    chk("bad_h_err", {31'd0, err}, 32'd1);
    chk("bad_h_busy", {31'd0, busy}, 32'd0);
    chk("bad_h_iwidth", {20'd0, enc_iwidth}, 32'd4);
    chk("bad_h_iheight", {16'd0, enc_iheight}, 32'd2);

    // frame 2: 4x1, stray olast in PRE, toggling s_valid, encoder error
    do_start(12'd4, 16'd1);
    enc_ovalid = 1'b1; enc_olast = 1'b1;
    @(posedge clk); #1;
    enc_ovalid = 1'b0; enc_olast = 1'b0;
    chk("pre_olast_done", {31'd0, done}, 32'd0);
    wait_pre(n_pre);
    chk("f2_pre_cycles", n_pre, 32'd367);
    iv_base = ivalid_cnt;
    send_pix(8'hA0, 1);
    send_pix(8'hA1, 1);
    send_pix(8'hA2, 1);
    send_pix(8'hA3, 0);
    finish_frame(1'b1, 16'd2);
    chk("f2_ivalid_pulses", ivalid_cnt - iv_base, 32'd4);

    // frame 3: start during DATA is ignored
    do_start(12'd4, 16'd2);
    wait_pre(n_pre);
    send_pix(8'h31, 0);
    send_pix(8'h32, 1);
    do_start(12'd100, 16'd5);
    chk("busy_start_iwidth", {20'd0, enc_iwidth}, 32'd4);
    chk("busy_start_err", {31'd0, err}, 32'd0);
    chk("busy_start_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 6; i++) send_pix(8'(8'h33 + i), 0);
    finish_frame(1'b0, 16'd3);

    // reset mid-DATA after three pixels
    do_start(12'd4, 16'd2);
    wait_pre(n_pre);
    send_pix(8'h51, 0);
    send_pix(8'h52, 0);
    send_pix(8'h53, 0);
    s_valid = 1'b0; s_data = 8'd0;
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    exp_q.delete();
    @(posedge clk); #1;
    rstn = 1'b1;
    do_start(12'd4, 16'd1);
    wait_pre(n_pre);
    chk("clean_pre_cycles", n_pre, 32'd368);
    for (int i = 0; i < 4; i++) send_pix(8'(8'hC0 + i), 0);
    finish_frame(1'b0, 16'd1);

`ifdef JLS_CTRL_TIMEOUT_EN
    // timeout: no olast, FIN 16 cycles after POST entry
    begin
      int k;
      do_start(12'd4, 16'd1);
      wait_pre(n_pre);
      for (int i = 0; i < 4; i++) send_pix(8'(8'hE0 + i), 0);
      s_valid = 1'b0; s_data = 8'd0;
      k = 0;
      while (!done && k < 100) begin
        @(posedge clk); #1;
        k++;
      end
      chk("timeout_cycles", k, 32'd16);
      chk("timeout_err", {31'd0, err}, 32'd1);
      @(posedge clk); #1;
      chk("timeout_frame_cnt", {16'd0, frame_cnt}, 32'd2);
    end
`endif

    repeat (3) @(posedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
